sterownik_kawiarki: RTL and testbench

Brew-cycle controller for the coffee machine. It sequences the shared heater, grinder and pump for one drink at a time: request, heat, grind, brew, done. It supervises water level, cup presence and heater timeout, and latches a fault code. It is a Moore FSM: actuator outputs depend only on the current state, and state transitions are synchronous.

---
 rtl/sterownik_kawiarki.sv | 188 ++++++++++++++++++
 tb/tb_sterownik_kawiarki.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sterownik_kawiarki.sv
// Brew-cycle controller: sequences heater, grinder and pump for one drink,
// supervises water, cup and heater timeout, and latches a fault code.
module sterownik_kawiarki #(
  parameter int unsigned GRIND_CYCLES    = 200,
  parameter int unsigned ESPRESSO_CYCLES = 500,
  parameter int unsigned LUNGO_CYCLES    = 1200,
  parameter int unsigned HEAT_TIMEOUT    = 4000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       lungo,
  input  logic       abort,
  input  logic       heat_ready,
  input  logic       water_ok,
  input  logic       cup_present,
  input  logic       fault_clr,
  output logic       heater_en,
  output logic       grinder_en,
  output logic       pump_en,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [2:0] state_out
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HEAT  = 3'd1;
  localparam logic [2:0] ST_GRIND = 3'd2;
  localparam logic [2:0] ST_BREW  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_FAULT = 3'd5;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_NO_WATER = 2'b01;
  localparam logic [1:0] FC_HEAT_TO  = 2'b10;
  localparam logic [1:0] FC_NO_CUP   = 2'b11;

  localparam logic [15:0] HEAT_LAST     = 16'(HEAT_TIMEOUT - 1);
  localparam logic [15:0] GRIND_LAST    = 16'(GRIND_CYCLES - 1);
  localparam logic [15:0] ESPRESSO_LAST = 16'(ESPRESSO_CYCLES - 1);
  localparam logic [15:0] LUNGO_LAST    = 16'(LUNGO_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sel_q, sel_d;
  logic [1:0]  code_q, code_d;
  logic [15:0] brew_last_s;
  logic        timed_s;

  // State, counter, selection and fault-code registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      sel_q   <= 1'b0;
      code_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      code_q  <= code_d;
    end
  end

  assign brew_last_s = sel_q ? LUNGO_LAST : ESPRESSO_LAST;
  assign timed_s     = (state_q == ST_HEAT) || (state_q == ST_GRIND) || (state_q == ST_BREW);

  // Next-state logic; abort outranks supervision, which outranks progression
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !water_ok) begin
          state_d = ST_FAULT;
          code_d  = FC_NO_WATER;
        end else if (start && cup_present) begin
          state_d = ST_HEAT;
          sel_d   = lungo;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HEAT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (heat_ready) begin
          state_d = ST_GRIND;
        end else if (cnt_q == HEAT_LAST) begin
          state_d = ST_FAULT;
          code_d  = FC_HEAT_TO;
        end else begin
          state_d = ST_HEAT;
        end
      end
      ST_GRIND: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == GRIND_LAST) begin
          state_d = ST_BREW;
        end else begin
          state_d = ST_GRIND;
        end
      end
      ST_BREW: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!water_ok) begin
          state_d = ST_FAULT;
          code_d  = FC_NO_WATER;
        end else if (!cup_present) begin
          state_d = ST_FAULT;
          code_d  = FC_NO_CUP;
        end else if (cnt_q == brew_last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_BREW;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_IDLE;
          code_d  = FC_NONE;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The counter restarts on any state entry
    if (state_d != state_q) begin
      cnt_d = 16'd0;
    end else if (timed_s) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = 16'd0;
    end
  end

  // Moore output decode from the state register only
  always_comb begin
    heater_en  = 1'b0;
    grinder_en = 1'b0;
    pump_en    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    fault      = 1'b0;
    case (state_q)
      ST_HEAT: begin
        heater_en = 1'b1;
        busy      = 1'b1;
      end
      ST_GRIND: begin
        heater_en  = 1'b1;
        grinder_en = 1'b1;
        busy       = 1'b1;
      end
      ST_BREW: begin
        heater_en = 1'b1;
        pump_en   = 1'b1;
        busy      = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      ST_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign fault_code = code_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_sterownik_kawiarki.sv
// Self-checking bench for sterownik_kawiarki: vector table, directed corner
// sequences and random stimulus against a countdown-based behavioural model.
module tb_sterownik_kawiarki;

  localparam int GRIND = 4;
  localparam int ESPR  = 6;
  localparam int LUNGO = 10;
  localparam int HTO   = 8;

  localparam int P_IDLE  = 0;
  localparam int P_HEAT  = 1;
  localparam int P_GRIND = 2;
  localparam int P_BREW  = 3;
  localparam int P_DONE  = 4;
  localparam int P_FAULT = 5;

  logic clk = 1'b0;
  logic reset, start, lungo, abort_i, heat_ready, water_ok, cup_present, fault_clr;
  logic heater_en, grinder_en, pump_en, busy, done, fault;
  logic [1:0] fault_code;
  logic [2:0] state_out;

  int tests = 0;
  int fails = 0;
  int done_count = 0;

  int m_phase, m_left, m_code;
  logic m_lungo;

  sterownik_kawiarki #(
    .GRIND_CYCLES(GRIND), .ESPRESSO_CYCLES(ESPR),
    .LUNGO_CYCLES(LUNGO), .HEAT_TIMEOUT(HTO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .lungo(lungo), .abort(abort_i),
    .heat_ready(heat_ready), .water_ok(water_ok), .cup_present(cup_present),
    .fault_clr(fault_clr), .heater_en(heater_en), .grinder_en(grinder_en),
    .pump_en(pump_en), .busy(busy), .done(done), .fault(fault),
    .fault_code(fault_code), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st, lg, ab, hr, wo, cp, fc;
    int   exp_state;
    int   exp_code;
  } vec_t;

  vec_t vecs[18];

  // {heater, grinder, pump, busy, done, fault, code[1:0], state[2:0]}
  function automatic logic [10:0] expect_vec(input int ph, input int code);
    logic h, g, p, b, d, f;
    h = (ph == P_HEAT) || (ph == P_GRIND) || (ph == P_BREW);
    g = (ph == P_GRIND);
    p = (ph == P_BREW);
    b = (ph >= P_HEAT) && (ph <= P_DONE);
    d = (ph == P_DONE);
    f = (ph == P_FAULT);
    return {h, g, p, b, d, f, 2'(code), 3'(ph)};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {heater_en, grinder_en, pump_en, busy, done, fault, fault_code, state_out};
  endfunction

  task automatic check_val(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string name);
    logic [10:0] e, g;
    e = expect_vec(m_phase, m_code);
    g = dut_vec();
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s: got %b, expected %b (h g p b d f code state) at %0t", name, g, e, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_left  = 0;
    m_code  = 0;
    m_lungo = 1'b0;
  endtask

  // Reference behaviour: each timed phase carries its remaining cycle budget
  task automatic model_step();
    case (m_phase)
      P_IDLE: begin
        if (start && !water_ok) begin
          m_phase = P_FAULT; m_code = 1;
        end else if (start && cup_present) begin
          m_phase = P_HEAT; m_left = HTO; m_lungo = lungo;
        end
      end
      P_HEAT: begin
        if (abort_i) m_phase = P_IDLE;
        else if (heat_ready) begin m_phase = P_GRIND; m_left = GRIND; end
        else begin
          m_left--;
          if (m_left == 0) begin m_phase = P_FAULT; m_code = 2; end
        end
      end
      P_GRIND: begin
        if (abort_i) m_phase = P_IDLE;
        else begin
          m_left--;
          if (m_left == 0) begin m_phase = P_BREW; m_left = m_lungo ? LUNGO : ESPR; end
        end
      end
      P_BREW: begin
        if (abort_i) m_phase = P_IDLE;
        else if (!water_ok) begin m_phase = P_FAULT; m_code = 1; end
        else if (!cup_present) begin m_phase = P_FAULT; m_code = 3; end
        else begin
          m_left--;
          if (m_left == 0) m_phase = P_DONE;
        end
      end
      P_DONE: m_phase = P_IDLE;
      P_FAULT: if (fault_clr) begin m_phase = P_IDLE; m_code = 0; end
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    if (done) done_count++;
    check_outputs("model");
  endtask

  task automatic quiet_inputs();
    start = 1'b0; lungo = 1'b0; abort_i = 1'b0; heat_ready = 1'b1;
    water_ok = 1'b1; cup_present = 1'b1; fault_clr = 1'b0;
  endtask

  task automatic run_to_brew(input logic lg);
    start = 1'b1; lungo = lg; heat_ready = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 20 && state_out != 3'd3; i++) cycle();
    check_val("reach_brew", int'(state_out), P_BREW);
  endtask

  function automatic vec_t mk(input logic st, hr, wo, cp, fc, ab, input int es, input int ec);
    vec_t v;
    v.st = st; v.lg = 1'b0; v.ab = ab; v.hr = hr; v.wo = wo; v.cp = cp; v.fc = fc;
    v.exp_state = es; v.exp_code = ec;
    return v;
  endfunction

  initial begin
    int pump_cycles, heat_cycles, done_before;

    // start, heat_ready, water_ok, cup, fault_clr, abort -> state, code
    vecs[0]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, P_IDLE,  0);
    vecs[1]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, P_IDLE,  0);
    vecs[2]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, P_HEAT,  0);
    vecs[3]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, P_GRIND, 0);
    for (int i = 4; i <= 6; i++)  vecs[i] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, P_GRIND, 0);
    for (int i = 7; i <= 12; i++) vecs[i] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, P_BREW, 0);
    vecs[13] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, P_DONE,  0);
    vecs[14] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, P_IDLE,  0);
    vecs[15] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, P_FAULT, 1);
    vecs[16] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, P_FAULT, 1);
    vecs[17] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, P_IDLE,  0);

    reset = 1'b0;
    quiet_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("in_reset");
    reset = 1'b1;
    cycle();
    check_val("after_reset_state", int'(state_out), P_IDLE);

    // Table: espresso run, ignored inputs, no-water start and clear
    for (int i = 0; i < 18; i++) begin
      start = vecs[i].st; lungo = vecs[i].lg; abort_i = vecs[i].ab;
      heat_ready = vecs[i].hr; water_ok = vecs[i].wo; cup_present = vecs[i].cp;
      fault_clr = vecs[i].fc;
      cycle();
      check_val($sformatf("vec%0d_state", i), int'(state_out), vecs[i].exp_state);
      check_val($sformatf("vec%0d_code", i), int'(fault_code), vecs[i].exp_code);
    end
    quiet_inputs();

    // Lungo selected, selection changed during GRIND
    done_before = done_count;
    start = 1'b1; lungo = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    lungo = 1'b0;
    pump_cycles = 0;
    for (int i = 0; i < 40 && done_count == done_before; i++) begin
      cycle();
      if (pump_en) pump_cycles++;
    end
    check_val("lungo_pump_cycles", pump_cycles, LUNGO);
    check_val("lungo_done_pulses", done_count - done_before, 1);

    // Heater never ready: timeout fault
    quiet_inputs();
    cycle();
    heat_ready = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    heat_cycles = 0;
    for (int i = 0; i < 20 && !fault; i++) begin
      if (state_out == 3'd1) heat_cycles++;
      cycle();
    end
    check_val("heat_timeout_cycles", heat_cycles, HTO);
    check_val("heat_timeout_code", int'(fault_code), 2);
    check_val("heat_timeout_heater", int'(heater_en), 0);
    cycle();
    check_val("fault_code_held", int'(fault_code), 2);
    fault_clr = 1'b1;
    cycle();
    check_val("clear_state", int'(state_out), P_IDLE);
    check_val("clear_code", int'(fault_code), 0);
    quiet_inputs();

    // Water lost in the third BREW cycle
    run_to_brew(1'b0);
    cycle();
    cycle();
    water_ok = 1'b0;
    cycle();
    check_val("water_fault_code", int'(fault_code), 1);
    check_val("water_fault_pump", int'(pump_en), 0);
    quiet_inputs(); fault_clr = 1'b1;
    cycle();
    quiet_inputs();

    // Cup removed in BREW with water present
    run_to_brew(1'b0);
    cup_present = 1'b0;
    cycle();
    check_val("cup_fault_code", int'(fault_code), 3);
    quiet_inputs(); fault_clr = 1'b1;
    cycle();
    quiet_inputs();

    // Abort in GRIND, then abort with water loss in BREW
    done_before = done_count;
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    abort_i = 1'b1;
    cycle();
    check_val("abort_grind_state", int'(state_out), P_IDLE);
    check_val("abort_grind_fault", int'(fault), 0);
    quiet_inputs();
    run_to_brew(1'b0);
    abort_i = 1'b1; water_ok = 1'b0;
    cycle();
    check_val("abort_brew_state", int'(state_out), P_IDLE);
    check_val("abort_brew_code", int'(fault_code), 0);
    check_val("abort_no_done", done_count - done_before, 0);
    quiet_inputs();

    // Asynchronous reset between edges in BREW
    run_to_brew(1'b1);
    cycle();
    #2;
    reset = 1'b0;
    #1;
    check_val("async_rst_pump", int'(pump_en), 0);
    check_val("async_rst_heater", int'(heater_en), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("post_rst_state", int'(state_out), P_IDLE);
    start = 1'b1; cup_present = 1'b0;
    cycle();
    check_val("start_no_cup", int'(state_out), P_IDLE);
    quiet_inputs();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      start       = ($urandom_range(99) < 30);
      lungo       = ($urandom_range(1) == 1);
      abort_i     = ($urandom_range(99) < 3);
      heat_ready  = ($urandom_range(99) < 40);
      water_ok    = ($urandom_range(99) < 96);
      cup_present = ($urandom_range(99) < 96);
      fault_clr   = ($urandom_range(99) < 20);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
